// File: rtl/game_pkg.sv
// Shared game definitions: one-hot status encoding used by the FSM and the
// VGA colour stage, plus the default win and time-limit constants.
package game_pkg;

    typedef enum logic [3:0] {
        ST_WAIT = 4'b1000,
        ST_PLAY = 4'b0100,
        ST_WIN  = 4'b0010,
        ST_LOSE = 4'b0001
    } status_t;

    localparam int WIN_SCORE_DEF  = 20;
    localparam int TIME_LIMIT_DEF = 1800;

endpackage : game_pkg

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous VGA VS into the Clk domain and turns each rising
// edge into a single registered Clk-wide frame_tick pulse.
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync0_r;
    logic sync1_r;
    logic prev_r;
    logic tick_r;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
            prev_r  <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync0_r <= frame_clk;
            sync1_r <= sync0_r;
            prev_r  <= sync1_r;
            tick_r  <= sync1_r & ~prev_r;
        end
    end

    assign frame_tick = tick_r;

endmodule : frame_tick_sync

// File: rtl/game_status_fsm.sv
// Game controller: wait/play/win/lose status, coin score, play timer and the
// new-run game_reset pulse. Define GAME_LIVES_EN for the lives/immunity variant.
module game_status_fsm
    import game_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int WIN_SCORE  = WIN_SCORE_DEF,
    parameter int TIME_LIMIT = TIME_LIMIT_DEF,
    parameter int TIME_W     = 11,
    parameter int END_HOLD   = 60
`ifdef GAME_LIVES_EN
    ,
    parameter int NUM_LIVES     = 3,
    parameter int INVULN_FRAMES = 90
`endif
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               start_key,
    input  logic               collision,
    input  logic               coin_hit,
    output logic [3:0]         status,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  frames_left,
    output logic               game_reset
`ifdef GAME_LIVES_EN
    ,
    output logic [1:0]         lives
`endif
);

    localparam int HOLD_W = $clog2(END_HOLD + 1);
    localparam logic [3:0] S_WAIT = ST_WAIT;
    localparam logic [3:0] S_PLAY = ST_PLAY;
    localparam logic [3:0] S_WIN  = ST_WIN;
    localparam logic [3:0] S_LOSE = ST_LOSE;

    logic [3:0]         state_r,  state_s;
    logic [SCORE_W-1:0] score_r,  score_s;
    logic [TIME_W-1:0]  frames_r, frames_s;
    logic [HOLD_W-1:0]  hold_r,   hold_s;
    logic               game_reset_r, game_reset_s;
    logic               key_armed_r;
    logic               key_press_s;
    logic               key_used_s;
    logic               hit_s;
    logic               frame_tick_s;
`ifdef GAME_LIVES_EN
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    logic [1:0]         lives_r,  lives_s;
    logic [INV_W-1:0]   invuln_r, invuln_s;
`endif

    frame_tick_sync u_frame_tick_sync (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick_s)
    );

    // A press only counts once the key has been seen released since its last use.
    assign key_press_s = start_key & key_armed_r;

    // Next-state and next-output computation for the game FSM.
    always_comb begin
        state_s      = state_r;
        score_s      = score_r;
        frames_s     = frames_r;
        hold_s       = hold_r;
        game_reset_s = 1'b0;
        key_used_s   = 1'b0;
`ifdef GAME_LIVES_EN
        lives_s      = lives_r;
        invuln_s     = invuln_r;
        hit_s        = collision && (invuln_r == INV_W'(0));
`else
        hit_s        = collision;
`endif
        case (state_r)
            S_WAIT: begin
                if (key_press_s) begin
                    state_s      = S_PLAY;
                    score_s      = SCORE_W'(0);
                    frames_s     = TIME_W'(TIME_LIMIT);
                    game_reset_s = 1'b1;
                    key_used_s   = 1'b1;
`ifdef GAME_LIVES_EN
                    lives_s      = 2'(NUM_LIVES);
                    invuln_s     = INV_W'(0);
`endif
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_PLAY: begin
                if (hit_s) begin
`ifdef GAME_LIVES_EN
                    lives_s = lives_r - 2'd1;
                    if (lives_r <= 2'd1) begin
                        state_s = S_LOSE;
                        hold_s  = HOLD_W'(0);
                    end else begin
                        invuln_s = INV_W'(INVULN_FRAMES);
                    end
`else
                    state_s = S_LOSE;
                    hold_s  = HOLD_W'(0);
`endif
                end else begin
                    if (coin_hit && (score_r < SCORE_W'(WIN_SCORE))) begin
                        score_s = score_r + 1'b1;
                    end else begin
                        score_s = score_r;
                    end
                    if (frame_tick_s && (frames_r != TIME_W'(0))) begin
                        frames_s = frames_r - 1'b1;
                    end else begin
                        frames_s = frames_r;
                    end
`ifdef GAME_LIVES_EN
                    if (frame_tick_s && (invuln_r != INV_W'(0))) begin
                        invuln_s = invuln_r - 1'b1;
                    end else begin
                        invuln_s = invuln_r;
                    end
`endif
                    // The winning coin outranks a simultaneous time-out.
                    if (coin_hit && (score_r == SCORE_W'(WIN_SCORE - 1))) begin
                        state_s = S_WIN;
                        hold_s  = HOLD_W'(0);
                    end else if (frame_tick_s && (frames_r == TIME_W'(1))) begin
                        state_s = S_LOSE;
                        hold_s  = HOLD_W'(0);
                    end else begin
                        state_s = S_PLAY;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (key_press_s && (hold_r == HOLD_W'(END_HOLD))) begin
                    state_s    = S_WAIT;
                    key_used_s = 1'b1;
                end else if (frame_tick_s && (hold_r < HOLD_W'(END_HOLD))) begin
                    hold_s = hold_r + 1'b1;
                end else begin
                    hold_s = hold_r;
                end
            end
            default: begin
                state_s = S_WAIT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= S_WAIT;
            score_r      <= SCORE_W'(0);
            frames_r     <= TIME_W'(TIME_LIMIT);
            hold_r       <= HOLD_W'(0);
            game_reset_r <= 1'b0;
            key_armed_r  <= 1'b0;
`ifdef GAME_LIVES_EN
            lives_r      <= 2'(NUM_LIVES);
            invuln_r     <= INV_W'(0);
`endif
        end else begin
            state_r      <= state_s;
            score_r      <= score_s;
            frames_r     <= frames_s;
            hold_r       <= hold_s;
            game_reset_r <= game_reset_s;
            if (key_used_s) begin
                key_armed_r <= 1'b0;
            end else if (!start_key) begin
                key_armed_r <= 1'b1;
            end else begin
                key_armed_r <= key_armed_r;
            end
`ifdef GAME_LIVES_EN
            lives_r      <= lives_s;
            invuln_r     <= invuln_s;
`endif
        end
    end

    assign status      = state_r;
    assign score       = score_r;
    assign frames_left = frames_r;
    assign game_reset  = game_reset_r;
`ifdef GAME_LIVES_EN
    assign lives       = lives_r;
`endif

endmodule : game_status_fsm

// File: tb/tb_game_status_fsm.sv
// Directed bench for game_status_fsm: a per-cycle vector table for start/coin
// behaviour plus hand-written multi-cycle sequences for timer, hold and lives.
module tb_game_status_fsm;

`ifdef GAME_LIVES_EN
    localparam int TL = 200;
`else
    localparam int TL = 4;
`endif
    localparam int WS = 3;
    localparam int EH = 3;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        start_key = 1'b1;
    logic        collision = 1'b0;
    logic        coin_hit = 1'b0;
    logic [3:0]  status;
    logic [7:0]  score;
    logic [10:0] frames_left;
    logic        game_reset;
`ifdef GAME_LIVES_EN
    logic [1:0]  lives;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    game_status_fsm #(
        .SCORE_W    (8),
        .WIN_SCORE  (WS),
        .TIME_LIMIT (TL),
        .TIME_W     (11),
        .END_HOLD   (EH)
`ifdef GAME_LIVES_EN
        ,
        .NUM_LIVES     (2),
        .INVULN_FRAMES (90)
`endif
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .start_key   (start_key),
        .collision   (collision),
        .coin_hit    (coin_hit),
        .status      (status),
        .score       (score),
        .frames_left (frames_left),
        .game_reset  (game_reset)
`ifdef GAME_LIVES_EN
        ,
        .lives       (lives)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       sk;
        logic       col;
        logic       coin;
        logic [3:0] st;
        int         sc;
        int         fl;
        logic       gr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic sk, input logic col, input logic coin);
        start_key = sk;
        collision = col;
        coin_hit  = coin;
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        coin_hit  = 1'b0;
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst status", status, 4'b1000);
        chk("rst score", score, 0);
        chk("rst frames", frames_left, TL);
        chk("rst game_reset", game_reset, 0);
        start_key = 1'b0;
        collision = 1'b0;
        coin_hit  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic enter_play(input string tag);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk({tag, " status"}, status, 4'b0100);
        chk({tag, " game_reset"}, game_reset, 1);
        chk({tag, " score"}, score, 0);
        chk({tag, " frames"}, frames_left, TL);
        step(1'b0, 1'b0, 1'b0);
        chk({tag, " game_reset drop"}, game_reset, 0);
    endtask

    initial begin
        // sk col coin | status score frames game_reset
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 0, TL, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 0, TL, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b1000, 0, TL, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 0, TL, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 0, TL, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 0, TL, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 1, TL, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1, TL, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 2, TL, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 3, TL, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'b0010, 3, TL, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0010, 3, TL, 1'b0};

        // Reset with the start key already held down.
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        chk("init status", status, 4'b1000);
        chk("init score", score, 0);
        chk("init frames", frames_left, TL);
        chk("init game_reset", game_reset, 0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].sk, vecs[i].col, vecs[i].coin);
            chk($sformatf("vec%0d status", i), status, vecs[i].st);
            chk($sformatf("vec%0d score", i), score, vecs[i].sc);
            chk($sformatf("vec%0d frames", i), frames_left, vecs[i].fl);
            chk($sformatf("vec%0d game_reset", i), game_reset, vecs[i].gr);
        end

        // WIN hold: early press ignored, press after EH ticks returns to WAIT.
        step(1'b1, 1'b0, 1'b0);
        chk("win early press", status, 4'b0010);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < EH; i++) tick();
        step(1'b1, 1'b0, 1'b0);
        chk("win->wait status", status, 4'b1000);
        chk("win->wait score frozen", score, WS);
        enter_play("play2");

        // Collision together with a coin at score 2.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("two coins score", score, 2);
        step(1'b0, 1'b1, 1'b1);
`ifdef GAME_LIVES_EN
        chk("col+coin status", status, 4'b0100);
        chk("col+coin lives", lives, 1);
`else
        chk("col+coin status", status, 4'b0001);
`endif
        chk("col+coin score", score, 2);

        do_reset();
        enter_play("play3");

        // Time-out: TL frame ticks, LOSE on the last one.
        for (int k = 1; k <= TL; k++) begin
            tick();
            if (TL - k < 4) chk($sformatf("frames after tick %0d", k), frames_left, TL - k);
            if (k == TL - 1) chk("status before last tick", status, 4'b0100);
        end
        chk("timeout status", status, 4'b0001);
        step(1'b1, 1'b0, 1'b0);
        chk("lose press hold0", status, 4'b0001);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < EH - 1; i++) tick();
        step(1'b1, 1'b0, 1'b0);
        chk("lose press hold-1", status, 4'b0001);
        step(1'b0, 1'b0, 1'b0);
        tick();
        step(1'b1, 1'b0, 1'b0);
        chk("lose->wait status", status, 4'b1000);
        chk("lose->wait frames frozen", frames_left, 0);

`ifdef GAME_LIVES_EN
        enter_play("play4");
        chk("lives load", lives, 2);
        step(1'b0, 1'b1, 1'b0);
        chk("first hit lives", lives, 1);
        chk("first hit status", status, 4'b0100);
        for (int i = 0; i < 89; i++) tick();
        chk("immune lives", lives, 1);
        chk("immune status", status, 4'b0100);
        step(1'b0, 1'b0, 1'b0);
        tick();
        step(1'b0, 1'b1, 1'b0);
        chk("second hit lives", lives, 0);
        chk("second hit status", status, 4'b0001);
        do_reset();
`endif

        // Reset asserted in the middle of a run.
        enter_play("play5");
        step(1'b0, 1'b0, 1'b1);
        chk("mid coin score", score, 1);
        #2;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_game_status_fsm
